// File: rtl/uart_rx_ctrl.sv
// AXI4-Lite read master that drains the axi_uartlite RX FIFO into a local FWFT byte FIFO.
// Optional macro UART_RX_ERR_EN adds status-error pulses and a sticky bad-response flag.
module uart_rx_ctrl #(
    parameter int DEPTH    = 16,
    parameter int POLL_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  data,
    output logic        valid,
    input  logic        ready,
    output logic [3:0]  araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
`ifdef UART_RX_ERR_EN
    ,
    output logic        err_overrun,
    output logic        err_frame,
    output logic        err_parity,
    output logic        err_resp
`endif
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POLL_W = $clog2(POLL_DIV + 2);

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [1:0] OKAY      = 2'b00;

    typedef enum logic [2:0] {IDLE, AR_STAT, R_STAT, AR_DATA, R_DATA, POLL} state_t;

    state_t            state, state_nxt;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_nxt;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [7:0]        head_nxt;
    logic              push, pop, room;
    logic              unused_rdata;

    assign unused_rdata = ^rdata[31:8];
    assign room = (count < CNT_W'(DEPTH));
    assign push = (state == R_DATA) && rvalid && (rresp == OKAY);
    assign pop  = valid && ready;

    always_comb begin
        state_nxt    = state;
        poll_cnt_nxt = poll_cnt;
        araddr       = 4'h0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        case (state)
            IDLE: state_nxt = AR_STAT;
            AR_STAT: begin
                araddr  = ADDR_STAT;
                arvalid = 1'b1;
                if (arready) state_nxt = R_STAT;
            end
            R_STAT: begin
                rready = 1'b1;
                if (rvalid) begin
                    if ((rresp == OKAY) && rdata[0] && room) begin
                        state_nxt = AR_DATA;
                    end else if (POLL_DIV == 0) begin
                        state_nxt = AR_STAT;
                    end else begin
                        state_nxt    = POLL;
                        poll_cnt_nxt = POLL_W'(POLL_DIV);
                    end
                end
            end
            AR_DATA: begin
                araddr  = ADDR_RX;
                arvalid = 1'b1;
                if (arready) state_nxt = R_DATA;
            end
            // a data read always goes straight back to status so a burst drains without polling
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) state_nxt = AR_STAT;
            end
            POLL: begin
                poll_cnt_nxt = poll_cnt - POLL_W'(1);
                if (poll_cnt <= POLL_W'(1)) state_nxt = AR_STAT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            poll_cnt <= '0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= poll_cnt_nxt;
        end
    end

    // Next head: the pushed byte when it lands in an otherwise empty FIFO, else the stored entry.
    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        head_nxt   = data;
        if (count_nxt != '0) begin
            if (push && (count == CNT_W'(pop))) head_nxt = rdata[7:0];
            else                                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            data   <= 8'h00;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            data   <= head_nxt;
        end
    end

`ifdef UART_RX_ERR_EN
    logic stat_okay;
    assign stat_okay = (state == R_STAT) && rvalid && (rresp == OKAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            err_overrun <= stat_okay && rdata[5];
            err_frame   <= stat_okay && rdata[6];
            err_parity  <= stat_okay && rdata[7];
            if (rready && rvalid && (rresp != OKAY)) err_resp <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: behavioural uartlite AXI slave, consumer, and a byte scoreboard.
module tb_uart_rx_ctrl;
    localparam int DEPTH    = 16;
    localparam int POLL_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef UART_RX_ERR_EN
    logic        err_overrun, err_frame, err_parity, err_resp;
`endif

    uart_rx_ctrl #(.DEPTH(DEPTH), .POLL_DIV(POLL_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef UART_RX_ERR_EN
        , .err_overrun(err_overrun), .err_frame(err_frame),
        .err_parity(err_parity), .err_resp(err_resp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] b; logic err; } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         stat_hs[$];
    int         data_hs[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         stab_err = 0;
    int         underflow = 0;
    int         ar_dly = 0;
    int         r_dly = 0;
    int         ovr_cnt = 0;
    bit         ready_en = 0;
    bit         in_rdata = 0;
    logic       v_before, v_after;
    logic [7:0] stat_extra = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] b, input logic err);
        rx_q.push_back('{b: b, err: err});
        if (!err) exp_q.push_back(b);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // uartlite model: answers one read at a time, sampling DUT signals on the falling edge
    initial begin : slave
        logic [3:0]  addr;
        logic [31:0] rd;
        logic [1:0]  rsp;
        rx_t         e;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        @(negedge clk);
        forever begin
            if (rst_n && arvalid) begin
                addr = araddr;
                for (int i = 0; i < ar_dly; i++) begin
                    @(negedge clk);
                    if (!arvalid || araddr != addr) stab_err++;
                end
                arready = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                if (addr == 4'h8) begin
                    stat_hs.push_back(cyc);
                    rd  = {24'hC3C3C3, stat_extra[7:1], (rx_q.size() != 0)};
                    rsp = 2'b00;
                    stat_extra = 8'h00;
                end else begin
                    data_hs.push_back(cyc);
                    in_rdata = 1;
                    if (rx_q.size() == 0) begin
                        underflow++;
                        rd  = '0;
                        rsp = 2'b00;
                    end else begin
                        e   = rx_q.pop_front();
                        rd  = {24'h5AA5C3, e.b};
                        rsp = e.err ? 2'b10 : 2'b00;
                    end
                end
                for (int i = 0; i < r_dly; i++) @(negedge clk);
                rdata  = rd;
                rresp  = rsp;
                rvalid = 1'b1;
                if (addr != 4'h8) v_before = valid;
                while (!rready) @(negedge clk);
                @(negedge clk);
                rvalid = 1'b0;
                rdata  = '0;
                rresp  = 2'b00;
                if (addr != 4'h8) begin
                    v_after  = valid;
                    in_rdata = 0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : consumer
        ready = 1'b0;
        forever begin
            @(negedge clk);
            ready = ready_en;
            if (valid && ready) begin
                check("pop_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("pop_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
            end
`ifdef UART_RX_ERR_EN
            if (err_overrun) ovr_cnt++;
`endif
        end
    end

    initial begin : main
        int n, d0;
        #1 rst_n = 1'b0;
        wait_neg(3);
        check("rst_arvalid", {31'b0, arvalid}, 0);
        check("rst_araddr", {28'b0, araddr}, 0);
        check("rst_rready", {31'b0, rready}, 0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_data", {24'b0, data}, 0);
        rst_n = 1'b1;

        // idle: only status reads, spaced by the poll interval
        wait_neg(100);
        n = stat_hs.size();
        check("idle_stat_reads", 32'(n >= 4), 1);
        if (n >= 4)
            for (int k = n - 3; k < n; k++)
                check("idle_poll_gap", stat_hs[k] - stat_hs[k-1], POLL_DIV + 2);
        check("idle_no_data_read", data_hs.size(), 0);
        check("idle_valid", {31'b0, valid}, 0);

        // single byte held until accepted
        load(8'h41, 1'b0);
        for (int i = 0; i < 200 && data_hs.size() == 0; i++) @(negedge clk);
        wait_neg(3);
        check("single_valid_before_push", {31'b0, v_before}, 0);
        check("single_valid_after_push", {31'b0, v_after}, 1);
        check("single_data", {24'b0, data}, 32'h41);
        wait_neg(10);
        check("single_hold_valid", {31'b0, valid}, 1);
        check("single_hold_data", {24'b0, data}, 32'h41);
        ready_en = 1;
        drain("single_drain", 50);
        wait_neg(2);
        check("single_empty_after_pop", {31'b0, valid}, 0);

        // burst drained back to back
        d0 = data_hs.size();
        for (int i = 0; i < 4; i++) load(8'h41 + 8'(i), 1'b0);
        drain("burst_drain", 300);
        check("burst_reads", data_hs.size() - d0, 4);
        if (data_hs.size() - d0 == 4)
            for (int k = d0 + 1; k < d0 + 4; k++)
                check("burst_gap", data_hs[k] - data_hs[k-1], 4);

        // backpressure: FIFO fills, remaining bytes stay in the uartlite
        ready_en = 0;
        wait_neg(2);
        d0 = data_hs.size();
        for (int i = 0; i < 20; i++) load(8'h60 + 8'(i), 1'b0);
        wait_neg(400);
        check("full_reads", data_hs.size() - d0, DEPTH);
        check("full_left_in_uart", rx_q.size(), 20 - DEPTH);
        check("full_valid", {31'b0, valid}, 1);
        check("full_head", {24'b0, data}, 32'h60);
        ready_en = 1;
        drain("full_release_drain", 2000);
        check("full_uart_empty", rx_q.size(), 0);

        // non-OKAY data read drops the byte
        d0 = data_hs.size();
        load(8'h77, 1'b1);
        load(8'h78, 1'b0);
        drain("drop_drain", 300);
        wait_neg(5);
        check("drop_reads", data_hs.size() - d0, 2);
`ifdef UART_RX_ERR_EN
        check("drop_err_resp", {31'b0, err_resp}, 1);
`endif

        // AXI stalls on both channels
        ar_dly = 3;
        r_dly  = 5;
        stab_err = 0;
        load(8'h5A, 1'b0);
        load(8'hA5, 1'b0);
        drain("stall_drain", 1000);
        check("stall_ar_stable", stab_err, 0);
        ar_dly = 0;
        r_dly  = 0;
        wait_neg(5);
        check("no_underflow", underflow, 0);

`ifdef UART_RX_ERR_EN
        ovr_cnt = 0;
        stat_extra = 8'h20;
        load(8'h21, 1'b0);
        drain("ovr_drain", 300);
        wait_neg(5);
        check("ovr_pulse_count", ovr_cnt, 1);
`endif

        // reset while a data read is outstanding
        ready_en = 0;
        wait_neg(2);
        load(8'h99, 1'b0);
        for (int i = 0; i < 200 && !valid; i++) @(negedge clk);
        check("pre_rst_valid", {31'b0, valid}, 1);
        r_dly = 6;
        load(8'hAA, 1'b0);
        for (int i = 0; i < 200 && !in_rdata; i++) @(negedge clk);
        wait_neg(1);
        check("pre_rst_rready", {31'b0, rready}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_arvalid", {31'b0, arvalid}, 0);
        check("async_rst_araddr", {28'b0, araddr}, 0);
        check("async_rst_rready", {31'b0, rready}, 0);
        check("async_rst_valid", {31'b0, valid}, 0);
        check("async_rst_data", {24'b0, data}, 0);
`ifdef UART_RX_ERR_EN
        check("async_rst_err_resp", {31'b0, err_resp}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
